// File: rtl/controller_rom.sv
// Microprogram store for the accumulator CPU controller: fixed 16x40 default table with a clocked patch overlay.
// Optional CONTROLLER_ROM_PARITY_EN adds a read parity output and a sticky patch parity-error flag.
module controller_rom (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  state,
    output logic [39:0] micro_instructions,
    input  logic        patch_we,
    input  logic [3:0]  patch_addr,
    input  logic [39:0] patch_data
`ifdef CONTROLLER_ROM_PARITY_EN
    ,
    input  logic        patch_par_in,
    output logic        micro_parity,
    output logic        patch_parity_err
`endif
);

    logic [15:0]       valid;
    logic [15:0][39:0] patch_mem;
    logic [39:0]       dflt_word;

    function automatic logic [39:0] uword(
        input logic        s1,
        input logic        s0,
        input logic [3:0]  n00,
        input logic [3:0]  n01,
        input logic [3:0]  n10,
        input logic [3:0]  n11,
        input logic [21:0] ctrl
    );
        return {s1, s0, n00, n01, n10, n11, ctrl};
    endfunction

    // Fields: sel1 (wait_/IR15), sel0 (AC15/IR14), next states for {m1,m0}=00,01,10,11, ctrl bus.
    always_comb begin
        dflt_word = 40'h0;
        case (state)
            4'd0:  dflt_word = uword(1'b0, 1'b0, 4'd1,  4'd1,  4'd1,  4'd1,  22'h000003);
            4'd1:  dflt_word = uword(1'b0, 1'b0, 4'd1,  4'd1,  4'd2,  4'd2,  22'h000004);
            4'd2:  dflt_word = uword(1'b0, 1'b0, 4'd3,  4'd3,  4'd3,  4'd3,  22'h000018);
            4'd3:  dflt_word = uword(1'b1, 1'b1, 4'd4,  4'd7,  4'd10, 4'd12, 22'h000020);
            4'd4:  dflt_word = uword(1'b0, 1'b0, 4'd5,  4'd5,  4'd5,  4'd5,  22'h000041);
            4'd5:  dflt_word = uword(1'b0, 1'b0, 4'd5,  4'd5,  4'd6,  4'd6,  22'h000004);
            4'd6:  dflt_word = uword(1'b0, 1'b0, 4'd0,  4'd0,  4'd0,  4'd0,  22'h000080);
            4'd7:  dflt_word = uword(1'b0, 1'b0, 4'd8,  4'd8,  4'd8,  4'd8,  22'h000041);
            4'd8:  dflt_word = uword(1'b0, 1'b0, 4'd8,  4'd8,  4'd9,  4'd9,  22'h000004);
            4'd9:  dflt_word = uword(1'b0, 1'b0, 4'd0,  4'd0,  4'd0,  4'd0,  22'h000300);
            4'd10: dflt_word = uword(1'b0, 1'b0, 4'd11, 4'd11, 4'd11, 4'd11, 22'h000C41);
            4'd11: dflt_word = uword(1'b0, 1'b0, 4'd11, 4'd11, 4'd0,  4'd0,  22'h001000);
            4'd12: dflt_word = uword(1'b0, 1'b0, 4'd0,  4'd13, 4'd0,  4'd13, 22'h002000);
            4'd13: dflt_word = uword(1'b0, 1'b0, 4'd0,  4'd0,  4'd0,  4'd0,  22'h004000);
            default: dflt_word = 40'h0;
        endcase
    end

    assign micro_instructions = valid[state] ? patch_mem[state] : dflt_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid <= '0;
        else if (patch_we)
            valid[patch_addr] <= 1'b1;
    end

    // Storage needs no reset: entries are only visible once their valid bit is set.
    always_ff @(posedge clk) begin
        if (patch_we && !rst)
            patch_mem[patch_addr] <= patch_data;
    end

`ifdef CONTROLLER_ROM_PARITY_EN
    assign micro_parity = ^micro_instructions;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            patch_parity_err <= 1'b0;
        else if (patch_we && (^patch_data) && !patch_par_in)
            patch_parity_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_controller_rom.sv
// Bench for controller_rom: default-table vectors, patch/reset sequences and a randomized patch/read run.
module tb_controller_rom;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  state;
    logic [39:0] micro_instructions;
    logic        patch_we;
    logic [3:0]  patch_addr;
    logic [39:0] patch_data;

    always #5 clk = ~clk;

    controller_rom dut (
        .clk(clk),
        .rst(rst),
        .state(state),
        .micro_instructions(micro_instructions),
        .patch_we(patch_we),
        .patch_addr(patch_addr),
        .patch_data(patch_data)
    );

    typedef struct {
        int     s1, s0, n00, n01, n10, n11;
        longint ctrl;
    } fields_t;

    typedef struct {
        logic [3:0]  st;
        logic [39:0] exp;
    } vec_t;

    fields_t     ft[16];
    logic [39:0] pmem[16];
    bit          pvalid[16];
    int          nvec = 0;
    int          nfail = 0;

    // Reference word from the field table using shifts of 64-bit integers.
    function automatic logic [39:0] dflt(input int s);
        longint w;
        w = (longint'(ft[s].s1) << 39) + (longint'(ft[s].s0) << 38)
          + (longint'(ft[s].n00) << 34) + (longint'(ft[s].n01) << 30)
          + (longint'(ft[s].n10) << 26) + (longint'(ft[s].n11) << 22) + ft[s].ctrl;
        return w[39:0];
    endfunction

    function automatic logic [39:0] model(input int s);
        return pvalid[s] ? pmem[s] : dflt(s);
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) pvalid[i] = 1'b0;
    endtask

    vec_t tv[$];

    initial begin
        ft[0]  = '{0, 0, 1, 1, 1, 1, 'h000003};
        ft[1]  = '{0, 0, 1, 1, 2, 2, 'h000004};
        ft[2]  = '{0, 0, 3, 3, 3, 3, 'h000018};
        ft[3]  = '{1, 1, 4, 7, 10, 12, 'h000020};
        ft[4]  = '{0, 0, 5, 5, 5, 5, 'h000041};
        ft[5]  = '{0, 0, 5, 5, 6, 6, 'h000004};
        ft[6]  = '{0, 0, 0, 0, 0, 0, 'h000080};
        ft[7]  = '{0, 0, 8, 8, 8, 8, 'h000041};
        ft[8]  = '{0, 0, 8, 8, 9, 9, 'h000004};
        ft[9]  = '{0, 0, 0, 0, 0, 0, 'h000300};
        ft[10] = '{0, 0, 11, 11, 11, 11, 'h000C41};
        ft[11] = '{0, 0, 11, 11, 0, 0, 'h001000};
        ft[12] = '{0, 0, 0, 13, 0, 13, 'h002000};
        ft[13] = '{0, 0, 0, 0, 0, 0, 'h004000};
        ft[14] = '{0, 0, 0, 0, 0, 0, 0};
        ft[15] = '{0, 0, 0, 0, 0, 0, 0};
        clear_model();

        tv.push_back('{4'd0,  40'h0444400003});
        tv.push_back('{4'd3,  40'hD1EB000020});
        tv.push_back('{4'd15, 40'h0000000000});
        for (int s = 0; s < 16; s++) tv.push_back('{4'(s), dflt(s)});

        rst = 1'b1; patch_we = 1'b0; patch_addr = 4'd0; patch_data = 40'h0; state = 4'd0;
        #12;
        check("reset_state0", micro_instructions, 40'h0444400003);
        @(negedge clk); rst = 1'b0;

        // Default table and next-state fields
        for (int i = 0; i < tv.size(); i++) begin
            state = tv[i].st; #1;
            check($sformatf("table_st%0d", tv[i].st), micro_instructions, tv[i].exp);
            check($sformatf("n00_st%0d", tv[i].st), 40'(micro_instructions[37:34]), 40'(ft[tv[i].st].n00));
            check($sformatf("n11_st%0d", tv[i].st), 40'(micro_instructions[25:22]), 40'(ft[tv[i].st].n11));
        end

        // Patch state 3; old word visible until the edge
        @(negedge clk);
        patch_we = 1'b1; patch_addr = 4'd3; patch_data = 40'hFFFFFFFFFF; state = 4'd3;
        #1 check("rdw_old_st3", micro_instructions, 40'hD1EB000020);
        @(posedge clk); #1;
        patch_we = 1'b0; pvalid[3] = 1'b1; pmem[3] = 40'hFFFFFFFFFF;
        check("patched_st3", micro_instructions, 40'hFFFFFFFFFF);
        state = 4'd0; #1 check("unpatched_st0", micro_instructions, 40'h0444400003);

        // Asynchronous reset mid-cycle
        state = 4'd3; #2 rst = 1'b1; #1;
        clear_model();
        check("async_rst_st3", micro_instructions, 40'hD1EB000020);
        #1 rst = 1'b0; #1;
        check("after_rst_st3", micro_instructions, 40'hD1EB000020);

        // Write to the address currently being read
        @(negedge clk);
        patch_we = 1'b1; patch_addr = 4'd5; patch_data = 40'h123456789A; state = 4'd5;
        #1 check("rdw_old_st5", micro_instructions, dflt(5));
        @(posedge clk); #1;
        patch_we = 1'b0; pvalid[5] = 1'b1; pmem[5] = 40'h123456789A;
        check("rdw_new_st5", micro_instructions, 40'h123456789A);
        @(posedge clk); #1 check("rewrite_keep_st5", micro_instructions, 40'h123456789A);

        // Overwrite an existing patch
        @(negedge clk);
        patch_we = 1'b1; patch_data = 40'h00000000F1;
        @(posedge clk); #1;
        patch_we = 1'b0; pmem[5] = 40'h00000000F1;
        check("overwrite_st5", micro_instructions, 40'h00000000F1);

        // Write held off while reset is asserted, accepted once released
        @(negedge clk);
        rst = 1'b1; clear_model();
        patch_we = 1'b1; patch_addr = 4'd0; patch_data = 40'hAAAAAAAAAA; state = 4'd0;
        @(posedge clk); #1 check("we_during_rst", micro_instructions, dflt(0));
        @(negedge clk); rst = 1'b0;
        #1 check("rst_released_pre_edge", micro_instructions, dflt(0));
        @(posedge clk); #1;
        patch_we = 1'b0; pvalid[0] = 1'b1; pmem[0] = 40'hAAAAAAAAAA;
        check("write_after_release", micro_instructions, 40'hAAAAAAAAAA);
        state = 4'd5; #1 check("st5_cleared_by_rst", micro_instructions, dflt(5));

        // Randomized writes, reads and occasional reset pulses
        for (int it = 0; it < 400; it++) begin
            logic [63:0] r64;
            @(negedge clk);
            r64 = {$urandom, $urandom};
            state = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b1; #1;
                clear_model();
                check("rand_rst", micro_instructions, model(state));
                rst = 1'b0;
            end else begin
                patch_we   = ($urandom_range(0, 2) == 0);
                patch_addr = ($urandom_range(0, 3) == 0) ? state : 4'($urandom_range(0, 15));
                patch_data = r64[39:0];
                #1 check("rand_pre_edge", micro_instructions, model(state));
                @(posedge clk); #1;
                if (patch_we) begin
                    pvalid[patch_addr] = 1'b1;
                    pmem[patch_addr] = patch_data;
                end
                patch_we = 1'b0;
                check("rand_post_edge", micro_instructions, model(state));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/controller_rom.md
Name: controller_rom

Overview:
- 16-entry x 40-bit microprogram store for the hardwired-sequence accumulator CPU controller.
- Indexed by the controller's 4-bit state register.
- Each word holds:
  - two condition-mux selects
  - four candidate next states
  - the 22-bit datapath control bus
- Read is combinational. A clocked patch port can override any entry until the next reset.

Parameters:
- none (depth 16 and width 40 are fixed by the word format)

Ports:
- clk  input  1  patch-port clock, rising edge
- rst  input  1  asynchronous active-high reset; clears all patches
- state  input  4  read address (current micro-state)
- micro_instructions  output  40  microword for address state
- patch_we  input  1  write enable for the patch port
- patch_addr  input  4  patch entry index
- patch_data  input  40  patch microword

Behaviour:
- Word format:
  - [39] sel1: 0 = wait_, 1 = IR15
  - [38] sel0: 0 = AC15, 1 = IR14
  - [37:34] N00, [33:30] N01, [29:26] N10, [25:22] N11
  - [21:0] ctrl
  - The controller picks the next state Nxy using the two mux results {m1, m0}.
- Default contents, listed as state: sel1 sel0 / N00 N01 N10 N11 / ctrl:
  - 0 FETCH0: 0 0 / 1 1 1 1 / 0x000003
  - 1 FETCH1: 0 0 / 1 1 2 2 / 0x000004 (holds while wait_=0)
  - 2 FETCH2: 0 0 / 3 3 3 3 / 0x000018
  - 3 DECODE: 1 1 / 4 7 10 12 / 0x000020
  - 4 LD0: 0 0 / 5 5 5 5 / 0x000041
  - 5 LD1: 0 0 / 5 5 6 6 / 0x000004
  - 6 LD2: 0 0 / 0 0 0 0 / 0x000080
  - 7 ADD0: 0 0 / 8 8 8 8 / 0x000041
  - 8 ADD1: 0 0 / 8 8 9 9 / 0x000004
  - 9 ADD2: 0 0 / 0 0 0 0 / 0x000300
  - 10 ST0: 0 0 / 11 11 11 11 / 0x000C41
  - 11 ST1: 0 0 / 11 11 0 0 / 0x001000
  - 12 BR0: 0 0 / 0 13 0 13 / 0x002000 (branch taken when AC15=1)
  - 13 BR1: 0 0 / 0 0 0 0 / 0x004000
  - 14, 15 unused: all fields 0, giving word 0x0000000000 and safe return to FETCH0.
- Read path:
  - micro_instructions = valid[state] ? patch_mem[state] : default[state].
  - Purely combinational; zero-cycle latency; no X for any 4-bit state.
- Patch port:
  - On rising clk with patch_we=1: patch_mem[patch_addr] <= patch_data and valid[patch_addr] <= 1.
  - Writing an already-patched entry replaces its previous patch.
- Read during write, same address: old word until the clk edge, new word immediately after.
- Reset:
  - rst asynchronously clears all 16 valid bits, so the output reverts to defaults at once, regardless of clk.
  - patch_mem contents are don't-care after reset.
  - patch_we is ignored while rst=1.
- Reset released on the same edge as patch_we=1: the write takes effect on that edge.

Optional Feature:
- Macro CONTROLLER_ROM_PARITY_EN.
- When defined:
  - Adds output micro_parity (1 bit), equal to the XOR of all 40 bits of micro_instructions, combinational.
  - Adds output patch_parity_err (1 bit), registered, async-cleared by rst.
  - patch_parity_err sets on a write whose patch_data has odd XOR while patch_par_in, a new 1-bit input, is 0. It is sticky until rst.
- When undefined:
  - Neither output exists, and patch_par_in does not exist.
  - Behaviour is otherwise identical.

Test Plan:
- rst pulse, state=0 -> micro_instructions=0x0444400003.
- state=3 after reset -> 0xD1EB000020; state=15 -> 0x0000000000.
- patch_we=1, patch_addr=3, patch_data=0xFFFFFFFFFF, one clk edge; then read each state:
  - state=3 -> 0xFFFFFFFFFF
  - state=0 -> 0x0444400003
- With state=3 patched, assert rst asynchronously mid-cycle -> output returns to 0xD1EB000020 before the next clk edge.
- Sweep state 0..15 -> each word matches the default field table; checker confirms Nxy fields equal the listed next states.
- Write to addr 5 while state=5 -> output unchanged before the edge, equals patch_data after the edge.
